// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame geometry and baud helpers.
// Imported by the TX engine, the baud generator and the future RX engine.
package uart_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t DATA  = 2'd2;
    localparam state_t STOP  = 2'd3;

    localparam int unsigned UART_DATA_BITS = 8;

    // Guard against a zero baud so elaboration reports the check, not a divide.
    function automatic int unsigned clks_per_bit(
        input int unsigned clk_freq,
        input int unsigned baud
    );
        if (baud == 0) begin
            return 0;
        end
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs while enabled, wraps every CLKS_PER_BIT cycles.
// Shared between the TX engine and the RX engine.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic bit_done_o
);

    localparam int unsigned W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] CNT_MAX = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max     = (cnt_q == CNT_MAX);
    assign bit_done_o = en_i & at_max;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i || at_max) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter draining a show-ahead FIFO onto tx_o.
// Frames run back-to-back while the FIFO holds data and tx_en_i is set.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tx_en_i,
    input  logic [7:0] fifo_rdata_i,
    input  logic       fifo_empty_i,
    output logic       fifo_re_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0]  LAST_IDX     = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx_engine: CLKS_PER_BIT must be at least 2");
    end

    state_t     state_q;
    state_t     state_d;
    logic       busy_q;
    logic       tx_q;
    logic       tx_d;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [2:0] idx_q;
    logic [2:0] idx_d;

    logic bit_done;
    logic last_bit;
    logic load_slot;
    logic load;

    assign last_bit  = (idx_q == LAST_IDX);
    assign load_slot = (state_q == IDLE) | ((state_q == STOP) & bit_done);
    // Reset gates the pop so a held-in-reset engine never drains the FIFO.
    assign load      = rst_ni & tx_en_i & ~fifo_empty_i & load_slot;

    assign fifo_re_o = load;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (state_q != IDLE),
        .clr_i      (load),
        .bit_done_o (bit_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done && last_bit) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = load ? START : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d    = tx_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        if (load) begin
            shift_d = fifo_rdata_i;
            tx_d    = 1'b0;
            idx_d   = 3'd0;
        end else begin
            unique case (state_q)
                IDLE: tx_d = 1'b1;
                START: begin
                    if (bit_done) begin
                        tx_d = shift_q[0];
                    end
                end
                DATA: begin
                    // Next bit is already at shift_q[1] before the shift lands.
                    if (bit_done) begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                        tx_d    = last_bit ? 1'b1 : shift_q[1];
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        tx_d = 1'b1;
                    end
                end
                default: tx_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_q    <= 1'b1;
            shift_q <= 8'h00;
            idx_q   <= 3'd0;
        end else begin
            tx_q    <= tx_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine at 10 clocks per bit.
// A small array-backed FIFO model feeds the engine and pops on fifo_re_o.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       tx_en;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_re;
    logic       tx;
    logic       busy;

    logic [7:0] mem [0:15];
    int         rd = 0;
    int         wr = 0;

    int n_vec = 0;
    int n_err = 0;

    assign fifo_empty = (rd == wr);
    assign fifo_rdata = mem[rd[3:0]];

    always #10 clk = ~clk;

    uart_tx_engine #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (5_000_000)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .tx_en_i      (tx_en),
        .fifo_rdata_i (fifo_rdata),
        .fifo_empty_i (fifo_empty),
        .fifo_re_o    (fifo_re),
        .tx_o         (tx),
        .busy_o       (busy)
    );

    always @(posedge clk) begin
        if (fifo_re && !fifo_empty) begin
            rd <= rd + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("re_while_empty", 32'(fifo_re & fifo_empty), 0);
    end

    task automatic push(input logic [7:0] b);
        mem[wr[3:0]] = b;
        wr = wr + 1;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_tx"}, 32'(tx), 1);
            chk({tag, "_busy"}, 32'(busy), 0);
            chk({tag, "_re"}, 32'(fifo_re), 0);
        end
    endtask

    // Call at the negedge of the pop cycle; walks n cycles of the frame.
    task automatic frame_check(input string tag, input logic [7:0] b,
                               input logic exp_re_end, input int drop_at,
                               input int n);
        logic [7:0] rx;
        logic       exp_tx;
        int         seg;
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seg = i / 10;
            if (seg == 0) exp_tx = 1'b0;
            else if (seg == 9) exp_tx = 1'b1;
            else exp_tx = b[seg-1];
            chk({tag, "_tx"}, 32'(tx), 32'(exp_tx));
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_re"}, 32'(fifo_re),
                (i == 99) ? 32'(exp_re_end) : 32'(0));
            if (seg >= 1 && seg <= 8 && (i % 10) == 5) rx[seg-1] = tx;
            if (i == drop_at) tx_en = 1'b0;
        end
        if (n == 100) chk({tag, "_decoded"}, 32'(rx), 32'(b));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        tx_en  = 1'b1;
        push(8'hA5);

        // Held in reset with data waiting: nothing moves.
        idle_check("rst_hold", 5);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_rel_re", 32'(fifo_re), 1);
        chk("rst_rel_busy", 32'(busy), 0);
        chk("rst_rel_tx", 32'(tx), 1);

        frame_check("a5", 8'hA5, 1'b0, -1, 100);
        idle_check("a5_after", 5);

        // Three queued bytes run back-to-back.
        @(posedge clk); #1;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        @(negedge clk);
        chk("b2b_re0", 32'(fifo_re), 1);
        frame_check("b00", 8'h00, 1'b1, -1, 100);
        frame_check("bff", 8'hFF, 1'b1, -1, 100);
        frame_check("b3c", 8'h3C, 1'b0, -1, 100);
        chk("b2b_empty", 32'(fifo_empty), 1);

        // Disabled engine ignores a non-empty FIFO.
        @(posedge clk); #1;
        tx_en = 1'b0;
        push(8'h12);
        push(8'h55);
        idle_check("dis", 20);
        @(posedge clk); #1;
        tx_en = 1'b1;
        @(negedge clk);
        chk("en_re", 32'(fifo_re), 1);
        frame_check("b12", 8'h12, 1'b0, 29, 100);
        idle_check("dis_after", 15);
        chk("dis_fifo_kept", 32'(fifo_empty), 0);

        // Reset in the middle of a 0x55 frame.
        @(posedge clk); #1;
        tx_en = 1'b1;
        @(negedge clk);
        chk("b55_re", 32'(fifo_re), 1);
        frame_check("b55", 8'h55, 1'b0, -1, 45);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_re", 32'(fifo_re), 0);
        idle_check("mid_rst_hold", 2);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        idle_check("mid_rst_after", 20);

        // Empty at STOP end, then data shows up three cycles later.
        @(posedge clk); #1;
        push(8'h81);
        @(negedge clk);
        chk("b81_re", 32'(fifo_re), 1);
        frame_check("b81", 8'h81, 1'b0, -1, 100);
        idle_check("late_gap", 2);
        @(posedge clk); #1;
        push(8'hC3);
        @(negedge clk);
        chk("late_re", 32'(fifo_re), 1);
        chk("late_busy", 32'(busy), 0);
        chk("late_tx", 32'(tx), 1);
        frame_check("bc3", 8'hC3, 1'b0, -1, 100);
        idle_check("end", 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
